cyx_stream_mux: RTL

// - Parametrised successor to the 2:1 combinational datapath mux: N-channel, WIDTH-bit stream multiplexer.
// - Each input has a valid/ready handshake. The output is registered and backed by a 2-entry skid buffer.
// - Channel choice is either external-select or round-robin arbitration.
// - Serves multi-source merge points in the CPU: writeback source, memory/IO response merge.

---
 rtl/cyx_mux_pkg.sv | 12 +
 rtl/cyx_skid_buf.sv | 72 +++++++
 rtl/cyx_stream_mux.sv | 112 +++++++++++
 3 files changed

// File: rtl/cyx_mux_pkg.sv
// Shared constants and helpers for the cyx_stream_mux N-channel stream multiplexer.
package cyx_mux_pkg;

  localparam int MODE_SELECT = 0;
  localparam int MODE_RR     = 1;

  // Channel-id width, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cyx_skid_buf.sv
// Two-entry valid/ready register stage with registered input ready and in-order output.
module cyx_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   occupancy_o
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         ready_q;
  logic         push, pop;

  assign push = in_valid_i && ready_q;
  assign pop  = (count_q != 2'd0) && out_ready_i;

  // Head is the visible output register; tail only fills when the consumer stalls.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = in_data_i;
        else                 tail_d = in_data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) head_d = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = in_data_i;
        end else begin
          head_d = tail_q;
          tail_d = in_data_i;
        end
      end
      default: ;
    endcase
  end

  // Ready stays low while reset is held and is computed from the next occupancy only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ready_q <= (count_d != 2'd2);
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = head_q;
  assign occupancy_o = count_q;

endmodule

// File: rtl/cyx_stream_mux.sv
// N-channel valid/ready stream mux (external select or round-robin) feeding a 2-entry skid buffer.
// Optional sticky out-of-range select flag err_sel is enabled by defining CYX_MUX_SELERR_EN.
module cyx_stream_mux
  import cyx_mux_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_CH = 4,
  parameter  int MODE   = MODE_SELECT,
  localparam int SEL_W  = clog2_min1(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch
`ifdef CYX_MUX_SELERR_EN
  ,
  output logic                    err_sel
`endif
);

  logic [SEL_W-1:0]       ptr_q, ptr_d;
  logic [SEL_W-1:0]       rr_grant;
  logic                   rr_found;
  logic [SEL_W-1:0]       scan_ch;
  int                     scan_sum;
  logic [SEL_W-1:0]       grant;
  logic                   grant_ok;
  logic                   sel_in_range;
  logic                   buf_ready;
  logic [1:0]             buf_occ;
  logic                   room;
  logic                   accept;
  logic [WIDTH+SEL_W-1:0] buf_out;

  assign sel_in_range = (int'(sel) < NUM_CH);

  // Round-robin scan starts one past the last accepted channel and wraps at NUM_CH.
  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    scan_ch  = '0;
    scan_sum = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      scan_sum = int'(ptr_q) + i;
      if (scan_sum >= NUM_CH) scan_sum = scan_sum - NUM_CH;
      scan_ch = SEL_W'(scan_sum);
      if (!rr_found && in_valid[scan_ch]) begin
        rr_found = 1'b1;
        rr_grant = scan_ch;
      end
    end
  end

  always_comb begin
    if (MODE == MODE_RR) begin
      grant    = rr_grant;
      grant_ok = rr_found;
    end else begin
      grant    = sel_in_range ? sel : '0;
      grant_ok = sel_in_range;
    end
  end

  assign room     = buf_ready && (buf_occ != 2'd2);
  assign accept   = grant_ok && room && in_valid[grant];
  assign in_ready = (grant_ok && room) ? (NUM_CH'(1) << grant) : '0;
  assign ptr_d    = accept ? grant : ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= SEL_W'(NUM_CH - 1);
    else        ptr_q <= ptr_d;
  end

  cyx_skid_buf #(
    .W (WIDTH + SEL_W)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (accept),
    .in_ready_o  (buf_ready),
    .in_data_i   ({in_data[int'(grant)*WIDTH +: WIDTH], grant}),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (buf_out),
    .occupancy_o (buf_occ)
  );

  assign out_data = buf_out[WIDTH+SEL_W-1:SEL_W];
  assign out_ch   = buf_out[SEL_W-1:0];

`ifdef CYX_MUX_SELERR_EN
  logic err_q;

  // Sticky until reset; round-robin builds never flag since sel is ignored there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((MODE == MODE_SELECT) && !sel_in_range && (|in_valid)) begin
      err_q <= 1'b1;
    end
  end

  assign err_sel = err_q;
`endif

endmodule
